// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle CPU with 16-bit instructions and generic data/PC widths.
// Instructions arrive on an imem req/ack port. Loads and stores use a dmem req/ack port.
module cpu_core_mc #(
   parameter int              DATA_W   = 16,
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic              i_clk,
   input  logic              i_rst,
   output logic              o_imem_req,
   output logic [PC_W-1:0]   o_imem_addr,
   input  logic              i_imem_ack,
   input  logic [15:0]       i_imem_rdata,
   output logic              o_dmem_req,
   output logic              o_dmem_we,
   output logic [DATA_W-1:0] o_dmem_addr,
   output logic [DATA_W-1:0] o_dmem_wdata,
   input  logic              i_dmem_ack,
   input  logic [DATA_W-1:0] i_dmem_rdata,
   output logic              o_retire,
   output logic              o_halted,
   output logic              o_carry,
   output logic              o_zero
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_MEM   = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [2:0] OP_RTYPE = 3'd0;
   localparam logic [2:0] OP_ADDI  = 3'd1;
   localparam logic [2:0] OP_LW    = 3'd2;
   localparam logic [2:0] OP_SW    = 3'd3;
   localparam logic [2:0] OP_BEQZ  = 3'd4;
   localparam logic [2:0] OP_JMP   = 3'd5;
   localparam logic [2:0] OP_HALT  = 3'd7;

   state_t              r_state;
   state_t              w_next_state;
   logic [PC_W-1:0]     r_pc;
   logic [15:0]         r_instr;
   logic [DATA_W-1:0]   r_regs [0:7];
   logic                r_carry;
   logic                r_zero;
   logic [DATA_W-1:0]   r_dmem_addr;
   logic [DATA_W-1:0]   r_dmem_wdata;
   logic                r_dmem_we;

   logic [2:0]          w_op;
   logic [2:0]          w_rd;
   logic [2:0]          w_rs1;
   logic [2:0]          w_rs2;
   logic [3:0]          w_func;
   logic [DATA_W-1:0]   w_rs1_val;
   logic [DATA_W-1:0]   w_rs2_val;
   logic [DATA_W-1:0]   w_rd_val;
   logic [DATA_W-1:0]   w_simm;
   logic [PC_W-1:0]     w_simm_pc;
   logic [PC_W-1:0]     w_pc_inc;
   logic [PC_W-1:0]     w_pc_br;
   logic [PC_W-1:0]     w_pc_jmp;
   logic [DATA_W-1:0]   w_alu_res;
   logic                w_alu_carry;
   logic                w_alu_wr;

   assign w_op      = r_instr[15:13];
   assign w_rd      = r_instr[12:10];
   assign w_rs1     = r_instr[9:7];
   assign w_rs2     = r_instr[6:4];
   assign w_func    = r_instr[3:0];
   // R0 is reset to zero and never written, so a plain array read returns 0 for it.
   assign w_rs1_val = r_regs[w_rs1];
   assign w_rs2_val = r_regs[w_rs2];
   assign w_rd_val  = r_regs[w_rd];
   assign w_simm    = {{(DATA_W-7){r_instr[6]}}, r_instr[6:0]};
   assign w_simm_pc = {{(PC_W-7){r_instr[6]}}, r_instr[6:0]};
   assign w_pc_inc  = r_pc + PC_W'(1);
   assign w_pc_br   = w_pc_inc + w_simm_pc;
   assign w_pc_jmp  = PC_W'(r_instr[12:0]);

   assign o_imem_addr  = r_pc;
   assign o_dmem_addr  = r_dmem_addr;
   assign o_dmem_wdata = r_dmem_wdata;
   assign o_dmem_we    = r_dmem_we;
   assign o_carry      = r_carry;
   assign o_zero       = r_zero;

   // ALU result, carry/borrow and writeback enable for R-type and ADDI.
   always_comb begin
      w_alu_res   = {DATA_W{1'b0}};
      w_alu_carry = 1'b0;
      w_alu_wr    = 1'b0;
      case (w_op)
         OP_RTYPE: begin
            w_alu_wr = 1'b1;
            case (w_func)
               4'd0: {w_alu_carry, w_alu_res} = {1'b0, w_rs1_val} + {1'b0, w_rs2_val};
               4'd1: begin
                  w_alu_res   = w_rs1_val - w_rs2_val;
                  w_alu_carry = (w_rs1_val < w_rs2_val);
               end
               4'd2: w_alu_res = w_rs1_val & w_rs2_val;
               4'd3: w_alu_res = w_rs1_val | w_rs2_val;
               4'd4: w_alu_res = w_rs1_val ^ w_rs2_val;
               4'd5: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(w_rs1_val) < $signed(w_rs2_val))};
               default: w_alu_wr = 1'b0;
            endcase
         end
         OP_ADDI: begin
            w_alu_wr = 1'b1;
            {w_alu_carry, w_alu_res} = {1'b0, w_rs1_val} + {1'b0, w_simm};
         end
         default: w_alu_wr = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FETCH: w_next_state = i_imem_ack ? S_EXEC : S_FETCH;
         S_EXEC: begin
            if ((w_op == OP_LW) || (w_op == OP_SW)) begin
               w_next_state = S_MEM;
            end else if (w_op == OP_HALT) begin
               w_next_state = S_HALT;
            end else begin
               w_next_state = S_FETCH;
            end
         end
         S_MEM:   w_next_state = i_dmem_ack ? S_FETCH : S_MEM;
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_FETCH;
      endcase
   end

   // Bus requests are gated by reset so nothing is requested while rst is high.
   always_comb begin
      o_imem_req = 1'b0;
      o_dmem_req = 1'b0;
      o_retire   = 1'b0;
      o_halted   = 1'b0;
      case (r_state)
         S_FETCH: o_imem_req = ~i_rst;
         S_EXEC:  o_retire   = (w_op != OP_LW) && (w_op != OP_SW);
         S_MEM: begin
            o_dmem_req = ~i_rst;
            o_retire   = i_dmem_ack;
         end
         S_HALT:  o_halted = 1'b1;
         default: o_halted = 1'b0;
      endcase
   end

   // Datapath: instruction latch, register file, flags, PC and dmem request fields.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pc         <= RESET_PC;
         r_instr      <= 16'h0000;
         r_carry      <= 1'b0;
         r_zero       <= 1'b0;
         r_dmem_addr  <= {DATA_W{1'b0}};
         r_dmem_wdata <= {DATA_W{1'b0}};
         r_dmem_we    <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_regs[i] <= {DATA_W{1'b0}};
         end
      end else begin
         case (r_state)
            S_FETCH: begin
               if (i_imem_ack) begin
                  r_instr <= i_imem_rdata;
               end
            end
            S_EXEC: begin
               case (w_op)
                  OP_RTYPE, OP_ADDI: begin
                     if (w_alu_wr) begin
                        if (w_rd != 3'd0) begin
                           r_regs[w_rd] <= w_alu_res;
                        end
                        r_carry <= w_alu_carry;
                        r_zero  <= (w_alu_res == {DATA_W{1'b0}});
                     end
                     r_pc <= w_pc_inc;
                  end
                  OP_LW, OP_SW: begin
                     r_dmem_addr  <= w_rs1_val + w_simm;
                     r_dmem_wdata <= w_rd_val;
                     r_dmem_we    <= (w_op == OP_SW);
                  end
                  OP_BEQZ: r_pc <= (w_rs1_val == {DATA_W{1'b0}}) ? w_pc_br : w_pc_inc;
                  OP_JMP:  r_pc <= w_pc_jmp;
                  OP_HALT: r_pc <= r_pc;
                  default: r_pc <= w_pc_inc;
               endcase
            end
            S_MEM: begin
               if (i_dmem_ack) begin
                  if (!r_dmem_we && (w_rd != 3'd0)) begin
                     r_regs[w_rd] <= i_dmem_rdata;
                  end
                  r_pc <= w_pc_inc;
               end
            end
            default: r_pc <= r_pc;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Bench for cpu_core_mc (DATA_W=16, PC_W=8, RESET_PC=0x10): memory responders with wait states,
// an instruction-level reference model checked at every retire, table vectors and directed sequences.
module tb_cpu_core_mc;
   localparam int         DW  = 16;
   localparam int         PW  = 8;
   localparam logic [7:0] RPC = 8'h10;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          o_imem_req, o_dmem_req, o_dmem_we, o_retire, o_halted, o_carry, o_zero;
   logic [PW-1:0] o_imem_addr;
   logic [DW-1:0] o_dmem_addr, o_dmem_wdata;
   logic          imem_ack = 1'b0;
   logic [15:0]   imem_rdata = 16'h0000;
   logic          dmem_ack = 1'b0;
   logic [DW-1:0] dmem_rdata = 16'h0000;

   cpu_core_mc #(.DATA_W(DW), .PC_W(PW), .RESET_PC(RPC)) dut (
      .i_clk(clk), .i_rst(rst),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
      .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
      .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
      .o_retire(o_retire), .o_halted(o_halted), .o_carry(o_carry), .o_zero(o_zero)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int lo7);
      logic [15:0] w;
      w[15:13] = op[2:0];
      w[12:10] = rd[2:0];
      w[9:7]   = rs1[2:0];
      w[6:0]   = lo7[6:0];
      return w;
   endfunction

   logic [15:0] imem [0:255];
   logic [15:0] dmem [0:65535];
   logic [15:0] mmem [0:65535];

   // Responder state
   int          imem_wait = 0, dmem_wait = 0, i_cnt = 0, d_cnt = 0, i_cycles = 0, d_cycles = 0;
   bit          rand_wait = 1'b0;
   logic [7:0]  i_first, last_faddr;
   logic [15:0] d_first, cap_daddr, cap_dwdata;
   logic        cap_dwe;

   always @(negedge clk) begin
      if (o_imem_req) begin
         if (i_cnt == 0) i_first = o_imem_addr;
         if (i_cnt >= imem_wait) begin
            imem_ack   = 1'b1;
            imem_rdata = imem[o_imem_addr];
            last_faddr = o_imem_addr;
            i_cycles   = i_cnt + 1;
            if (imem_wait > 0) chk("imem_addr_stable", o_imem_addr, i_first);
         end else begin
            imem_ack = 1'b0;
            i_cnt++;
         end
      end else begin
         imem_ack = 1'b0;
         i_cnt    = 0;
         if (rand_wait) imem_wait = $urandom_range(0, 3);
      end
   end

   always @(negedge clk) begin
      if (o_dmem_req) begin
         if (d_cnt == 0) d_first = o_dmem_addr;
         if (d_cnt >= dmem_wait) begin
            dmem_ack   = 1'b1;
            cap_daddr  = o_dmem_addr;
            cap_dwdata = o_dmem_wdata;
            cap_dwe    = o_dmem_we;
            d_cycles   = d_cnt + 1;
            if (o_dmem_we) dmem[o_dmem_addr] = o_dmem_wdata;
            dmem_rdata = o_dmem_we ? 16'h0000 : dmem[o_dmem_addr];
            if (dmem_wait > 0) chk("dmem_addr_stable", o_dmem_addr, d_first);
         end else begin
            dmem_ack = 1'b0;
            d_cnt++;
         end
      end else begin
         dmem_ack = 1'b0;
         d_cnt    = 0;
         if (rand_wait) dmem_wait = $urandom_range(0, 3);
      end
   end

   // Reference model: architectural state advanced one whole instruction per retire
   int         m_pc, mreg [8], retire_cnt;
   bit         m_c, m_z, m_halt;
   logic [7:0] faddr_q [$];

   task automatic model_reset();
      m_pc = RPC; m_c = 1'b0; m_z = 1'b0; m_halt = 1'b0; retire_cnt = 0;
      for (int i = 0; i < 8; i++) mreg[i] = 0;
      for (int i = 0; i < 65536; i++) mmem[i] = dmem[i];
      faddr_q.delete();
   endtask

   task automatic model_step();
      logic [15:0] ins;
      int op, rd, rs1, rs2, fn, a, b, simm, res, nxt, addr, sa, sb;
      bit wr, c;
      faddr_q.push_back(last_faddr);
      chk("fetch_pc", last_faddr, m_pc);
      ins  = imem[m_pc];
      op   = ins[15:13]; rd = ins[12:10]; rs1 = ins[9:7]; rs2 = ins[6:4]; fn = ins[3:0];
      a    = mreg[rs1];  b  = mreg[rs2];
      simm = ins[6] ? int'(ins[6:0]) - 128 : int'(ins[6:0]);
      nxt  = m_pc + 1; wr = 1'b0; res = 0; c = 1'b0;
      case (op)
         0: if (fn <= 5) begin
            wr = 1'b1;
            case (fn)
               0: begin res = a + b; c = (res > 65535); end
               1: begin res = a - b; c = (a < b); end
               2: res = a & b;
               3: res = a | b;
               4: res = a ^ b;
               default: begin
                  sa = (a >= 32768) ? a - 65536 : a;
                  sb = (b >= 32768) ? b - 65536 : b;
                  res = (sa < sb) ? 1 : 0;
               end
            endcase
            res = res & 65535; m_c = c; m_z = (res == 0);
         end
         1: begin
            res = a + (simm & 65535); m_c = (res > 65535);
            res = res & 65535; m_z = (res == 0); wr = 1'b1;
         end
         2: begin
            addr = (a + simm) & 65535;
            chk("ld_addr", cap_daddr, addr); chk("ld_we", cap_dwe, 0);
            res = mmem[addr]; wr = 1'b1;
         end
         3: begin
            addr = (a + simm) & 65535;
            chk("st_addr", cap_daddr, addr); chk("st_we", cap_dwe, 1);
            chk("st_data", cap_dwdata, mreg[rd]);
            mmem[addr] = 16'(mreg[rd]);
         end
         4: if (a == 0) nxt = m_pc + 1 + simm;
         5: nxt = ins[12:0];
         7: begin nxt = m_pc; m_halt = 1'b1; end
         default: ;
      endcase
      if (wr && rd != 0) mreg[rd] = res;
      m_pc = nxt & 255;
   endtask

   always begin
      @(negedge clk); #1;
      if (!rst && o_retire) begin
         retire_cnt++;
         model_step();
         @(posedge clk); #1;
         if (!rst) begin
            chk("carry", o_carry, m_c);
            chk("zero", o_zero, m_z);
            chk("halted", o_halted, m_halt);
         end
      end
   end

   task automatic start_prog();
      rst = 1'b1;
      @(negedge clk);
      model_reset();
      rst = 1'b0;
   endtask

   task automatic run_until_halt(input int max_cyc);
      int n = 0;
      while (!o_halted && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk("halt_reached", o_halted, 1);
   endtask

   task automatic wait_retires(input int cnt, input int max_cyc);
      int n = 0;
      while (retire_cnt < cnt && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk("retire_budget", (retire_cnt >= cnt), 1);
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 256; i++) imem[i] = 16'hC000;
   endtask

   typedef struct {
      logic [3:0]  func;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        c;
      logic        z;
   } alu_vec_t;

   alu_vec_t   vecs [12];
   logic [7:0] exp_pc [8];
   int         n, req_cnt, ret_cnt;

   initial begin
      vecs[0]  = '{4'd0, 16'h0005, 16'hFFFF, 16'h0004, 1'b1, 1'b0};
      vecs[1]  = '{4'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
      vecs[2]  = '{4'd0, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0};
      vecs[3]  = '{4'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1};
      vecs[4]  = '{4'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
      vecs[5]  = '{4'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0};
      vecs[6]  = '{4'd3, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b0};
      vecs[7]  = '{4'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1};
      vecs[8]  = '{4'd5, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0};
      vecs[9]  = '{4'd5, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
      vecs[10] = '{4'd5, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0};
      vecs[11] = '{4'd6, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0};
      exp_pc = '{8'h10, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h04, 8'h04, 8'h04};
      for (int i = 0; i < 65536; i++) dmem[i] = 16'h0000;

      // Reset, including a reset pulse in the middle of a waited fetch
      clear_imem();
      for (int r = 1; r < 8; r++) imem[RPC + r - 1] = enc(3, r, 0, 32 + r);
      imem[RPC + 7] = 16'hE000;
      for (int r = 1; r < 8; r++) dmem[32 + r] = 16'hA5A5;
      imem_wait = 3;
      repeat (2) @(negedge clk);
      chk("rst_imem_req", o_imem_req, 0);
      chk("rst_dmem_req", o_dmem_req, 0);
      chk("rst_retire", o_retire, 0);
      chk("rst_halted", o_halted, 0);
      chk("rst_carry", o_carry, 0);
      chk("rst_zero", o_zero, 0);
      model_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("fetch_pending_req", o_imem_req, 1);
      rst = 1'b1;
      #1;
      chk("rst_gates_req", o_imem_req, 0);
      @(negedge clk);
      model_reset();
      rst = 1'b0;
      n = 0;
      while (!o_imem_req && n < 10) begin @(negedge clk); n++; end
      chk("first_fetch_addr", o_imem_addr, RPC);
      run_until_halt(400);
      for (int r = 1; r < 8; r++) chk("reg_reset_zero", dmem[32 + r], 0);
      chk("fetch_wait_cycles", i_cycles, 4);

      // ALU sequence, zero-wait then with imem wait states
      clear_imem();
      imem[RPC + 0] = enc(1, 1, 0, 5);
      imem[RPC + 1] = enc(1, 2, 0, 127);
      imem[RPC + 2] = enc(0, 3, 1, 2 * 16 + 0);
      imem[RPC + 3] = enc(3, 3, 0, 0);
      imem[RPC + 4] = enc(0, 4, 1, 1 * 16 + 1);
      imem[RPC + 5] = enc(3, 4, 0, 1);
      imem[RPC + 6] = 16'hE000;
      for (int pass = 0; pass < 2; pass++) begin
         imem_wait = (pass == 0) ? 0 : 3;
         dmem[0] = 16'hFFFF; dmem[1] = 16'hFFFF;
         start_prog();
         wait_retires(3, 100);
         chk("add_carry", o_carry, 1);
         chk("add_zero", o_zero, 0);
         run_until_halt(200);
         chk("add_result", dmem[0], 16'h0004);
         chk("sub_result", dmem[1], 16'h0000);
         chk("sub_zero", o_zero, 1);
         chk("sub_carry", o_carry, 0);
         chk("alu_retires", retire_cnt, 7);
      end

      // Table-driven ALU vectors
      imem_wait = 0;
      for (int v = 0; v < 12; v++) begin
         clear_imem();
         imem[RPC + 0] = enc(2, 1, 0, 0);
         imem[RPC + 1] = enc(2, 2, 0, 1);
         imem[RPC + 2] = enc(0, 3, 1, 2 * 16 + int'(vecs[v].func));
         imem[RPC + 3] = enc(3, 3, 0, 2);
         imem[RPC + 4] = 16'hE000;
         dmem[0] = vecs[v].a; dmem[1] = vecs[v].b; dmem[2] = 16'hDEAD;
         start_prog();
         run_until_halt(100);
         chk("vec_result", dmem[2], vecs[v].res);
         chk("vec_carry", o_carry, vecs[v].c);
         chk("vec_zero", o_zero, vecs[v].z);
      end

      // Load/store with a 2-cycle dmem delay
      clear_imem();
      imem[RPC + 0] = enc(1, 1, 0, 7);
      imem[RPC + 1] = enc(3, 1, 0, 3);
      imem[RPC + 2] = enc(2, 5, 0, 3);
      imem[RPC + 3] = enc(3, 5, 0, 4);
      imem[RPC + 4] = 16'hE000;
      dmem[3] = 16'h0000; dmem[4] = 16'h0000;
      dmem_wait = 2;
      start_prog();
      run_until_halt(200);
      chk("sw_mem", dmem[3], 16'h0007);
      chk("lw_sw_mem", dmem[4], 16'h0007);
      chk("st_last_addr", cap_daddr, 16'h0004);
      chk("st_last_data", cap_dwdata, 16'h0007);
      chk("dmem_wait_cycles", d_cycles, 3);
      dmem_wait = 0;

      // Control flow: JMP truncation, PC wrap, branch not-taken/taken, self-loop
      clear_imem();
      imem[RPC]   = 16'hBFFF;
      imem[8'hFF] = 16'hC000;
      imem[8'h00] = enc(1, 1, 0, 1);
      imem[8'h01] = enc(4, 0, 1, 5);
      imem[8'h02] = enc(4, 0, 0, 1);
      imem[8'h03] = 16'hE000;
      imem[8'h04] = enc(4, 0, 0, 127);
      start_prog();
      wait_retires(8, 200);
      for (int k = 0; k < 8; k++) begin
         if (k < faddr_q.size()) chk("flow_pc", faddr_q[k], exp_pc[k]);
         else chk("flow_pc_missing", k, faddr_q.size());
      end
      chk("flow_not_halted", o_halted, 0);

      // R0 writes discarded, then HALT stays quiet
      clear_imem();
      imem[RPC + 0] = enc(1, 0, 0, 5);
      imem[RPC + 1] = enc(2, 0, 0, 9);
      imem[RPC + 2] = enc(3, 0, 0, 10);
      imem[RPC + 3] = 16'hE000;
      dmem[9] = 16'h1234; dmem[10] = 16'hBEEF;
      start_prog();
      run_until_halt(100);
      chk("r0_stays_zero", dmem[10], 16'h0000);
      chk("halt_retires", retire_cnt, 4);
      req_cnt = 0; ret_cnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (o_imem_req) req_cnt++;
         if (o_retire) ret_cnt++;
      end
      chk("halt_no_fetch", req_cnt, 0);
      chk("halt_no_retire", ret_cnt, 0);
      chk("halt_sticky", o_halted, 1);

      // Random program against the reference model, random wait states
      for (int i = 0; i < 256; i++) begin
         imem[i] = 16'($urandom());
         if (imem[i][15:13] == 3'd7) imem[i][15:13] = 3'd6;
      end
      for (int i = 0; i < 65536; i++) dmem[i] = 16'($urandom());
      rand_wait = 1'b1;
      start_prog();
      wait_retires(400, 20000);
      rst = 1'b1;
      rand_wait = 1'b0;
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
